// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared FSM states, requester IDs and SRAM address width
package sram_arbiter_pkg;
  localparam int ADDR_W = 21;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
  typedef enum logic [1:0] {ID_DL = 2'd0, ID_VID = 2'd1, ID_BUS = 2'd2} req_id_t;
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester handshakes and SRAM pins of the arbiter
interface sram_arbiter_if;
  logic dl_req, vid_req, bus_req;
  logic [sram_arbiter_pkg::ADDR_W-1:0] dl_addr, vid_addr, bus_addr;
  logic [7:0] dl_wdata, bus_wdata;
  logic bus_we;
  logic dl_ack, vid_ack, bus_ack;
  logic [7:0] rdata;
  logic [sram_arbiter_pkg::ADDR_W-1:0] SRAM_ADDR;
  logic [7:0] SRAM_DOUT, SRAM_DIN;
  logic SRAM_DOE, SRAM_WE_n, busy;
  modport master (
    output dl_req, vid_req, bus_req, dl_addr, vid_addr, bus_addr, dl_wdata, bus_wdata, bus_we, SRAM_DIN,
    input dl_ack, vid_ack, bus_ack, rdata, SRAM_ADDR, SRAM_DOUT, SRAM_DOE, SRAM_WE_n, busy
  );
  modport slave (
    input dl_req, vid_req, bus_req, dl_addr, vid_addr, bus_addr, dl_wdata, bus_wdata, bus_we, SRAM_DIN,
    output dl_ack, vid_ack, bus_ack, rdata, SRAM_ADDR, SRAM_DOUT, SRAM_DOE, SRAM_WE_n, busy
  );
endinterface

// File: rtl/sram_arb_priority.sv
// sram_arb_priority: picks the winning requester; bus preempts video once the streak is full
module sram_arb_priority
  import sram_arbiter_pkg::*;
#(
  parameter int VIDEO_BURST_MAX = 4
) (
  input  logic       dl_req_i,
  input  logic       vid_req_i,
  input  logic       bus_req_i,
  input  logic [3:0] vid_streak_i,
  output logic       valid_o,
  output req_id_t    winner_o
);
  logic bus_due;
  always_comb begin
    bus_due  = bus_req_i && vid_streak_i == 4'(VIDEO_BURST_MAX);
    valid_o  = dl_req_i | vid_req_i | bus_req_i;
    winner_o = dl_req_i ? ID_DL : bus_due ? ID_BUS : vid_req_i ? ID_VID : ID_BUS;
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: three-way SRAM arbiter running one SETUP/STROBE/DONE access per grant
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ACCESS_CYCLES   = 2,
  parameter int VIDEO_BURST_MAX = 4
) (
  input logic           clock,
  input logic           reset,
  sram_arbiter_if.slave arb
);
  state_t              state_q, state_d;
  req_id_t             id_q, id_d, win_id;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d, rdata_q, rdata_d;
  logic                we_q, we_d, win_valid;
  logic [3:0]          cnt_q, cnt_d, streak_q, streak_d;

  sram_arb_priority #(.VIDEO_BURST_MAX(VIDEO_BURST_MAX)) u_prio (
    .dl_req_i     (arb.dl_req),
    .vid_req_i    (arb.vid_req),
    .bus_req_i    (arb.bus_req),
    .vid_streak_i (streak_q),
    .valid_o      (win_valid),
    .winner_o     (win_id)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= ID_DL;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    case (state_q)
      IDLE: if (win_valid) begin
        state_d  = SETUP;
        id_d     = win_id;
        addr_d   = win_id == ID_DL ? arb.dl_addr : win_id == ID_VID ? arb.vid_addr : arb.bus_addr;
        wdata_d  = win_id == ID_DL ? arb.dl_wdata : win_id == ID_BUS ? arb.bus_wdata : 8'h00;
        we_d     = win_id == ID_DL || (win_id == ID_BUS && arb.bus_we);
        // streak only grows while the bus is actually being held off
        streak_d = (win_id == ID_BUS || !arb.bus_req) ? 4'd0 :
                   (win_id == ID_VID && streak_q != 4'(VIDEO_BURST_MAX)) ? streak_q + 4'd1 : streak_q;
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 4'd0;
      end
      STROBE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ACCESS_CYCLES - 1)) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          rdata_d = we_q ? rdata_q : arb.SRAM_DIN;
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  assign arb.busy      = state_q != IDLE;
  assign arb.SRAM_ADDR = addr_q;
  assign arb.SRAM_DOUT = wdata_q;
  assign arb.SRAM_DOE  = we_q && state_q != IDLE;
  assign arb.SRAM_WE_n = !(we_q && state_q == STROBE);
  assign arb.rdata     = rdata_q;
  assign arb.dl_ack    = state_q == DONE && id_q == ID_DL;
  assign arb.vid_ack   = state_q == DONE && id_q == ID_VID;
  assign arb.bus_ack   = state_q == DONE && id_q == ID_BUS;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors, corner sequences and a randomized transaction-level model
module tb_sram_arbiter;
  localparam int AC  = 2;
  localparam int VBM = 4;

  typedef struct {
    logic [2:0]  req;
    logic        we;
    logic [20:0] addr;
    logic [7:0]  wd;
    logic [7:0]  din;
    logic [2:0]  eack;
    logic [20:0] eaddr;
    logic        ewr;
    logic [7:0]  edout;
    logic [7:0]  erd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if sif();
  sram_arbiter #(.ACCESS_CYCLES(AC), .VIDEO_BURST_MAX(VBM)) dut (.clock(clk), .reset(rst), .arb(sif.slave));

  int n_chk = 0;
  int n_pass = 0;
  logic rnd_mode = 1'b0;
  logic [7:0] din_v = 8'h00;
  logic [7:0] last_rd = 8'h00;
  logic [2:0] ackv;
  vec_t vecs[10];

  function automatic logic [7:0] mem_f(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h5A;
  endfunction

  assign sif.SRAM_DIN = rnd_mode ? mem_f(sif.SRAM_ADDR) : din_v;
  assign ackv = {sif.bus_ack, sif.vid_ack, sif.dl_ack};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_reqs();
    sif.dl_req = 1'b0;
    sif.vid_req = 1'b0;
    sif.bus_req = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [2:0] got = 3'b000;
    int lat = -1, we_lo = 0, doe_n = 0;
    logic [20:0] a = '0;
    logic [7:0] d = 8'h00, r = 8'h00;
    @(posedge clk); #1;
    {sif.bus_req, sif.vid_req, sif.dl_req} = v.req;
    sif.bus_we = v.we;
    sif.bus_addr = v.addr;
    sif.dl_addr = v.addr ^ 21'h100000;
    sif.vid_addr = v.addr ^ 21'h080000;
    sif.bus_wdata = v.wd;
    sif.dl_wdata = v.wd ^ 8'hFF;
    din_v = v.din;
    for (int k = 0; k < 12 && lat < 0; k++) begin
      @(negedge clk);
      if (!sif.SRAM_WE_n) we_lo++;
      if (sif.SRAM_DOE) doe_n++;
      if (ackv != 3'b000) begin
        got = ackv; lat = k; a = sif.SRAM_ADDR; d = sif.SRAM_DOUT; r = sif.rdata;
      end
    end
    @(posedge clk); #1;
    clear_reqs();
    check($sformatf("vec%0d_ack", idx), 32'(got), 32'(v.eack));
    check($sformatf("vec%0d_latency", idx), 32'(lat), 32'(AC + 2));
    check($sformatf("vec%0d_we_low_cycles", idx), 32'(we_lo), 32'(v.ewr ? AC : 0));
    check($sformatf("vec%0d_doe_cycles", idx), 32'(doe_n), 32'(v.ewr ? AC + 2 : 0));
    check($sformatf("vec%0d_addr", idx), 32'(a), 32'(v.eaddr));
    check($sformatf("vec%0d_rdata", idx), 32'(r), 32'(v.ewr ? last_rd : v.erd));
    if (v.ewr) check($sformatf("vec%0d_dout", idx), 32'(d), 32'(v.edout));
    else last_rd = v.erd;
  endtask

  task automatic run_random(input int cycles);
    int c_free = 0, p_ack = -1, we_lo = 0, streak = 0;
    logic [2:0] p_id = 3'b000, w;
    logic [20:0] p_addr = '0;
    logic [7:0] p_dout = 8'h00;
    logic p_we = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      sif.dl_req = $urandom_range(0, 99) < 30;
      sif.vid_req = $urandom_range(0, 99) < 70;
      sif.bus_req = $urandom_range(0, 99) < 80;
      sif.dl_addr = 21'($urandom);
      sif.vid_addr = 21'($urandom);
      sif.bus_addr = 21'($urandom);
      sif.dl_wdata = 8'($urandom);
      sif.bus_wdata = 8'($urandom);
      sif.bus_we = 1'($urandom);
      @(negedge clk);
      if (!sif.SRAM_WE_n) we_lo++;
      check("rnd_ack", 32'(ackv), 32'(c == p_ack ? p_id : 3'b000));
      check("rnd_busy", 32'(sif.busy), 32'(c < c_free));
      if (c == p_ack) begin
        check("rnd_addr", 32'(sif.SRAM_ADDR), 32'(p_addr));
        check("rnd_doe", 32'(sif.SRAM_DOE), 32'(p_we));
        check("rnd_we_low_cycles", 32'(we_lo), 32'(p_we ? AC : 0));
        if (p_we) begin
          check("rnd_dout", 32'(sif.SRAM_DOUT), 32'(p_dout));
          check("rnd_rdata_kept", 32'(sif.rdata), 32'(last_rd));
        end else begin
          check("rnd_rdata", 32'(sif.rdata), 32'(mem_f(p_addr)));
          last_rd = mem_f(p_addr);
        end
      end else check("rnd_rdata_hold", 32'(sif.rdata), 32'(last_rd));
      if (c >= c_free && (sif.dl_req || sif.vid_req || sif.bus_req)) begin
        w = sif.dl_req ? 3'b001 : (sif.bus_req && streak == VBM) ? 3'b100 : sif.vid_req ? 3'b010 : 3'b100;
        streak = (w == 3'b100 || !sif.bus_req) ? 0 : (w == 3'b010) ? ((streak < VBM) ? streak + 1 : VBM) : streak;
        p_id = w;
        p_addr = w == 3'b001 ? sif.dl_addr : w == 3'b010 ? sif.vid_addr : sif.bus_addr;
        p_we = w == 3'b001 || (w == 3'b100 && sif.bus_we);
        p_dout = w == 3'b001 ? sif.dl_wdata : sif.bus_wdata;
        p_ack = c + AC + 2;
        c_free = p_ack + 1;
        we_lo = 0;
      end
    end
  endtask

  initial begin
    logic [2:0] order[$];
    logic [2:0] a;
    int overlap, extra, n_dl, n_bus, found;
    logic drop;
    vecs[0] = '{3'b100, 1'b1, 21'h000123, 8'h5A, 8'h00, 3'b100, 21'h000123, 1'b1, 8'h5A, 8'h00};
    vecs[1] = '{3'b100, 1'b0, 21'h00ABCD, 8'h00, 8'hC3, 3'b100, 21'h00ABCD, 1'b0, 8'h00, 8'hC3};
    vecs[2] = '{3'b001, 1'b0, 21'h01F0F0, 8'h11, 8'h00, 3'b001, 21'h11F0F0, 1'b1, 8'hEE, 8'h00};
    vecs[3] = '{3'b010, 1'b1, 21'h000040, 8'h00, 8'h7E, 3'b010, 21'h080040, 1'b0, 8'h00, 8'h7E};
    vecs[4] = '{3'b011, 1'b0, 21'h000200, 8'h00, 8'h99, 3'b001, 21'h100200, 1'b1, 8'hFF, 8'h00};
    vecs[5] = '{3'b110, 1'b1, 21'h1FFFFF, 8'h00, 8'h24, 3'b010, 21'h17FFFF, 1'b0, 8'h00, 8'h24};
    vecs[6] = '{3'b101, 1'b0, 21'h000000, 8'h80, 8'h55, 3'b001, 21'h100000, 1'b1, 8'h7F, 8'h00};
    vecs[7] = '{3'b111, 1'b1, 21'h0000FF, 8'h3C, 8'h00, 3'b001, 21'h1000FF, 1'b1, 8'hC3, 8'h00};
    vecs[8] = '{3'b100, 1'b0, 21'h1FFFFF, 8'h00, 8'hFF, 3'b100, 21'h1FFFFF, 1'b0, 8'h00, 8'hFF};
    vecs[9] = '{3'b100, 1'b0, 21'h000000, 8'h00, 8'h00, 3'b100, 21'h000000, 1'b0, 8'h00, 8'h00};
    clear_reqs();
    sif.bus_we = 1'b0;
    sif.dl_addr = '0; sif.vid_addr = '0; sif.bus_addr = '0;
    sif.dl_wdata = 8'h00; sif.bus_wdata = 8'h00;
    #12;
    check("rst_busy", 32'(sif.busy), 32'(0));
    check("rst_we_n", 32'(sif.SRAM_WE_n), 32'(1));
    check("rst_doe", 32'(sif.SRAM_DOE), 32'(0));
    check("rst_addr", 32'(sif.SRAM_ADDR), 32'(0));
    check("rst_dout", 32'(sif.SRAM_DOUT), 32'(0));
    check("rst_rdata", 32'(sif.rdata), 32'(0));
    check("rst_acks", 32'(ackv), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply(vecs[i], i);

    // all three requesters at once, each drops its request after its own ack
    overlap = 0; extra = 0;
    @(posedge clk); #1;
    sif.dl_req = 1'b1; sif.vid_req = 1'b1; sif.bus_req = 1'b1;
    for (int k = 0; k < 40 && order.size() < 3; k++) begin
      @(negedge clk);
      if (!$onehot0(ackv)) overlap++;
      a = ackv;
      if (a != 3'b000) order.push_back(a);
      @(posedge clk); #1;
      if (a[0]) sif.dl_req = 1'b0;
      if (a[1]) sif.vid_req = 1'b0;
      if (a[2]) sif.bus_req = 1'b0;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ackv != 3'b000) extra++;
    end
    check("simul_count", 32'(order.size()), 32'(3));
    check("simul_first_dl", 32'(order.size() > 0 ? order[0] : 3'b000), 32'(3'b001));
    check("simul_second_vid", 32'(order.size() > 1 ? order[1] : 3'b000), 32'(3'b010));
    check("simul_third_bus", 32'(order.size() > 2 ? order[2] : 3'b000), 32'(3'b100));
    check("simul_overlap", 32'(overlap), 32'(0));
    check("simul_extra_acks", 32'(extra), 32'(0));

    // video and bus held: four video grants then one bus grant, repeating
    order.delete();
    @(posedge clk); #1;
    sif.vid_req = 1'b1; sif.bus_req = 1'b1; sif.bus_we = 1'b0;
    for (int k = 0; k < 120 && order.size() < 10; k++) begin
      @(negedge clk);
      if (ackv != 3'b000) order.push_back(ackv);
    end
    @(posedge clk); #1;
    clear_reqs();
    check("streak_count", 32'(order.size()), 32'(10));
    for (int i = 0; i < 10; i++)
      check($sformatf("streak_ack%0d", i), 32'(i < order.size() ? order[i] : 3'b000), 32'(i % 5 == 4 ? 3'b100 : 3'b010));

    // asynchronous reset in the middle of a write strobe
    @(posedge clk); #1;
    sif.bus_req = 1'b1; sif.bus_we = 1'b1; sif.bus_addr = 21'h0055AA; sif.bus_wdata = 8'hA7;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      @(negedge clk);
      if (!sif.SRAM_WE_n) found = 1;
    end
    check("abort_strobe_seen", 32'(found), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("abort_we_n", 32'(sif.SRAM_WE_n), 32'(1));
    check("abort_busy", 32'(sif.busy), 32'(0));
    check("abort_doe", 32'(sif.SRAM_DOE), 32'(0));
    check("abort_ack", 32'(ackv), 32'(0));
    @(posedge clk); #1;
    sif.bus_req = 1'b0;
    rst = 1'b0;
    last_rd = 8'h00;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ackv != 3'b000) extra++;
    end
    check("abort_no_ack", 32'(extra), 32'(0));
    apply(vecs[1], 100);

    // bus pulse for one cycle during a download access is never granted
    n_dl = 0; n_bus = 0;
    @(posedge clk); #1;
    sif.dl_req = 1'b1; sif.dl_addr = 21'h001234; sif.dl_wdata = 8'h42;
    @(posedge clk); #1;
    sif.bus_req = 1'b1;
    @(posedge clk); #1;
    sif.bus_req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sif.dl_ack) n_dl++;
      if (sif.bus_ack) n_bus++;
      drop = sif.dl_ack;
      @(posedge clk); #1;
      if (drop) sif.dl_req = 1'b0;
    end
    check("pulse_dl_acks", 32'(n_dl), 32'(1));
    check("pulse_bus_acks", 32'(n_bus), 32'(0));

    rst = 1'b1;
    @(posedge clk); #1;
    clear_reqs();
    rst = 1'b0;
    last_rd = 8'h00;
    rnd_mode = 1'b1;
    run_random(3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
